// File: rtl/alu_issuer_if.sv
// ============================================================================
// Module   : alu_issuer_if
// Purpose  : Request/response handshake bundle between a sequencer and alu_issuer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_issuer_if #(
  parameter int WIDTH = 64
) ();
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [1:0]       req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );
endinterface

`default_nettype wire

// File: rtl/alu_issuer.sv
// ============================================================================
// Module   : alu_issuer
// Purpose  : Queues ALU requests, drives the ALU, returns results in order.
//            Optional result self-check enabled by macro ALU_ISSUER_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_issuer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_issuer_if.slave      bus,
  output logic [WIDTH-1:0] SrcA,
  output logic [WIDTH-1:0] SrcB,
  output logic [1:0]       ALUControl,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [3:0]       ALUFlags,
  output logic [3:0]       sticky_flags,
  output logic [31:0]      op_count,
  input  logic             clear,
  output logic             err_mismatch
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_ENT_W = 2 * WIDTH + 2;
  localparam logic [c_PTR_W:0] c_FULL_CNT = (c_PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [c_ENT_W-1:0]  fifo_q [DEPTH];
  logic [c_PTR_W-1:0]  wptr_q, rptr_q;
  logic [c_PTR_W:0]    count_q;
  logic [WIDTH-1:0]    srca_q, srcb_q, result_q;
  logic [1:0]          ctl_q;
  logic [3:0]          flags_q, sticky_q;
  logic [31:0]         opcnt_q;
  logic                rsp_valid_q, rsp_valid_d;

  logic w_full, w_empty, w_push, w_pop, w_capture;

  assign w_full  = (count_q == c_FULL_CNT);
  assign w_empty = (count_q == '0);
  assign w_push  = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_capture   = 1'b1;
        rsp_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!w_empty) begin
            w_pop   = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Queue storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_q[wptr_q] <= {bus.req_op, bus.req_b, bus.req_a};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rsp_valid_q <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      srca_q      <= '0;
      srcb_q      <= '0;
      ctl_q       <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      sticky_q    <= '0;
      opcnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      if (w_push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (w_pop) begin
        {ctl_q, srcb_q, srca_q} <= fifo_q[rptr_q];
        rptr_q <= rptr_q + 1'b1;
      end
      if (w_push && !w_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!w_push && w_pop) begin
        count_q <= count_q - 1'b1;
      end
      if (w_capture) begin
        result_q <= ALUResult;
        flags_q  <= ALUFlags;
      end
      // clear wins over a same-cycle capture, which then goes uncounted.
      if (clear) begin
        sticky_q <= '0;
        opcnt_q  <= '0;
      end else if (w_capture) begin
        sticky_q <= sticky_q | ALUFlags;
        opcnt_q  <= opcnt_q + 32'd1;
      end
    end
  end

`ifdef ALU_ISSUER_CHECK_EN
  logic [WIDTH-1:0] w_expect;
  logic             err_q;

  always_comb begin
    w_expect = '0;
    unique case (ctl_q)
      2'b00:   w_expect = srca_q + srcb_q;
      2'b01:   w_expect = srca_q - srcb_q;
      2'b10:   w_expect = srca_q & srcb_q;
      default: w_expect = srca_q | srcb_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (w_capture && (ALUResult != w_expect)) begin
      err_q <= 1'b1;
    end
  end

  assign err_mismatch = err_q;
`else
  assign err_mismatch = 1'b0;
`endif

  assign bus.req_ready  = !w_full && !rst;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_flags  = flags_q;
  assign SrcA           = srca_q;
  assign SrcB           = srcb_q;
  assign ALUControl     = ctl_q;
  assign sticky_flags   = sticky_q;
  assign op_count       = opcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issuer.sv
// ============================================================================
// Module   : tb_alu_issuer
// Purpose  : Scoreboard bench for alu_issuer with a behavioural ALU model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_issuer;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [63:0] SrcA, SrcB, ALUResult;
  logic [1:0]  ALUControl;
  logic [3:0]  ALUFlags, sticky_flags;
  logic [31:0] op_count;
  logic        err_mismatch;
  logic [63:0] inj;

  alu_issuer_if #(.WIDTH(64)) bus ();

  alu_issuer #(.WIDTH(64), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .SrcA         (SrcA),
    .SrcB         (SrcB),
    .ALUControl   (ALUControl),
    .ALUResult    (ALUResult),
    .ALUFlags     (ALUFlags),
    .sticky_flags (sticky_flags),
    .op_count     (op_count),
    .clear        (clear),
    .err_mismatch (err_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {flags[3:0] = V,C,Z,N ; result[63:0]}.
  function automatic logic [67:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] op);
    logic [63:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'b00: begin
        r = a + b;
        c = ({1'b0, a} + {1'b0, b}) > 65'h0_FFFF_FFFF_FFFF_FFFF;
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      2'b01: begin
        r = a - b;
        c = (a >= b);
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {v, c, (r == 64'd0), r[63], r};
  endfunction

  logic [67:0] alu_w;
  assign alu_w     = ref_alu(SrcA, SrcB, ALUControl);
  assign ALUResult = alu_w[63:0] ^ inj;
  assign ALUFlags  = alu_w[67:64];

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [67:0] sb_q[$];
  int          exp_cnt;
  logic [3:0]  exp_sticky;
  bit          chk_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  bit          held_v;
  logic [63:0] held_res;
  logic [3:0]  held_fl;
  logic [67:0] mexp;

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else if (bus.rsp_valid) begin
      if (held_v) begin
        chk("stall_result", bus.rsp_result, held_res);
        chk("stall_flags", 64'(bus.rsp_flags), 64'(held_fl));
      end
      if (bus.rsp_ready) begin
        held_v = 1'b0;
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
        end else begin
          mexp = sb_q.pop_front();
          chk("rsp_result", bus.rsp_result, mexp[63:0]);
          chk("rsp_flags", 64'(bus.rsp_flags), 64'(mexp[67:64]));
          if (chk_cnt) begin
            exp_cnt++;
            exp_sticky = exp_sticky | mexp[67:64];
            chk("op_count", 64'(op_count), 64'(exp_cnt));
            chk("sticky_flags", 64'(sticky_flags), 64'(exp_sticky));
          end
        end
      end else begin
        held_v   = 1'b1;
        held_res = bus.rsp_result;
        held_fl  = bus.rsp_flags;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic do_reset();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    clear         = 1'b0;
    rst           = 1'b1;
    sb_q.delete();
    exp_cnt    = 0;
    exp_sticky = 4'd0;
    chk_cnt    = 1'b1;
    @(negedge clk);
    chk("ready_in_reset", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    int t;
    bit done;
    t    = 0;
    done = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    while (!done) begin
      @(negedge clk);
      if (bus.req_ready) begin
        sb_q.push_back(ref_alu(a, b, op) ^ {4'd0, inj});
        done = 1'b1;
      end
      @(posedge clk); #1;
      t++;
      if (!done && t > 50) begin
        fail_timeout("send");
        done = 1'b1;
      end
    end
    bus.req_valid = 1'b0;
  endtask

  // Single op into an idle block with latency checks, then one handshake.
  task automatic single_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    bus.rsp_ready = 1'b0;
    send(a, b, op);
    @(negedge clk);
    chk("lat_n0_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    chk("lat_n1_valid", 64'(bus.rsp_valid), 64'd0);
    chk("pop_srca", SrcA, a);
    chk("pop_srcb", SrcB, b);
    chk("pop_ctl", 64'(ALUControl), 64'(op));
    @(negedge clk);
    chk("lat_n2_valid", 64'(bus.rsp_valid), 64'd1);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    bus.rsp_ready = 1'b1;
    t = 0;
    while (sb_q.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk(name, 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation time bound expired");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int accepted, t;
    bit acc;
    inj        = 64'd0;
    rst        = 1'b1;
    clear      = 1'b0;
    exp_cnt    = 0;
    exp_sticky = 4'd0;
    chk_cnt    = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a     = 64'd0;
    bus.req_b     = 64'd0;
    bus.req_op    = 2'd0;
    bus.rsp_ready = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_srca", SrcA, 64'd0);
    chk("rst_count", 64'(op_count), 64'd0);
    chk("rst_err", 64'(err_mismatch), 64'd0);
    @(posedge clk); #1;

    // Add, then subtract to zero.
    single_op(64'd105, 64'd215, 2'b00);
    chk("t1_result", bus.rsp_result, 64'd320);
    chk("t1_z", 64'(bus.rsp_flags[1]), 64'd0);
    chk("t1_count", 64'(op_count), 64'd1);
    single_op(64'd105, 64'd105, 2'b01);
    chk("t2_result", bus.rsp_result, 64'd0);
    chk("t2_z", 64'(bus.rsp_flags[1]), 64'd1);
    chk("t2_sticky_z", 64'(sticky_flags[1]), 64'd1);

    // Back-to-back AND then OR with rsp_ready held high.
    bus.rsp_ready = 1'b1;
    send(64'd105, 64'd215, 2'b10);
    send(64'd105, 64'd215, 2'b11);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.rsp_valid && t < 20);
    if (!bus.rsp_valid) fail_timeout("b2b_first");
    chk("b2b_first_val", bus.rsp_result, 64'd65);
    @(negedge clk);
    chk("b2b_gap", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    chk("b2b_second_valid", 64'(bus.rsp_valid), 64'd1);
    chk("b2b_second_val", bus.rsp_result, 64'd255);
    @(posedge clk); #1;
    wait_drain("b2b_drain");

    // Capacity under a stalled consumer.
    bus.rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 9; i++) begin
      bus.req_valid = 1'b1;
      bus.req_a     = 64'(i * 1000 + 7);
      bus.req_b     = 64'(i * 3 + 1);
      bus.req_op    = 2'(i);
      @(negedge clk);
      if (bus.req_ready) begin
        sb_q.push_back(ref_alu(bus.req_a, bus.req_b, bus.req_op));
        accepted++;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("cap_accepted", 64'(accepted), 64'd5);
    chk("cap_ready_low", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    wait_drain("cap_drain");
    chk("cap_err", 64'(err_mismatch), 64'd0);

    // clear during the ISSUE cycle.
    chk("pre_clear_count", 64'(op_count), 64'(exp_cnt));
    chk_cnt = 1'b0;
    send(64'd105, 64'd215, 2'b01);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("clr_valid", 64'(bus.rsp_valid), 64'd1);
    chk("clr_count", 64'(op_count), 64'd0);
    chk("clr_sticky", 64'(sticky_flags), 64'd0);
    @(posedge clk); #1;
    wait_drain("clr_drain");
    chk("clr_count_after", 64'(op_count), 64'd0);

    // Reset while a response is held.
    bus.rsp_ready = 1'b0;
    send(64'd7, 64'd9, 2'b00);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.rsp_valid && t < 20);
    if (!bus.rsp_valid) fail_timeout("hold_wait");
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("hr_valid", 64'(bus.rsp_valid), 64'd0);
    chk("hr_ready", 64'(bus.req_ready), 64'd1);
    chk("hr_srca", SrcA, 64'd0);
    chk("hr_srcb", SrcB, 64'd0);
    chk("hr_ctl", 64'(ALUControl), 64'd0);
    chk("hr_result", bus.rsp_result, 64'd0);
    chk("hr_flags", 64'(bus.rsp_flags), 64'd0);
    chk("hr_sticky", 64'(sticky_flags), 64'd0);
    chk("hr_count", 64'(op_count), 64'd0);
    chk("hr_err", 64'(err_mismatch), 64'd0);
    @(posedge clk); #1;
    single_op(64'd105, 64'd215, 2'b00);
    chk("hr_op_result", bus.rsp_result, 64'd320);
    chk("hr_op_count", 64'(op_count), 64'd1);

    // Randomized traffic with random consumer backpressure.
    bus.req_valid = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!bus.req_valid && $urandom_range(0, 2) != 0) begin
        bus.req_valid = 1'b1;
        bus.req_a     = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                    : {$urandom, $urandom};
        bus.req_b     = ($urandom_range(0, 3) == 0) ? bus.req_a : {$urandom, $urandom};
        bus.req_op    = 2'($urandom_range(0, 3));
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus.req_valid && bus.req_ready;
      if (acc) sb_q.push_back(ref_alu(bus.req_a, bus.req_b, bus.req_op));
      @(posedge clk); #1;
      if (acc) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    wait_drain("rand_drain");
    chk("rand_count", 64'(op_count), 64'(exp_cnt));
    chk("rand_sticky", 64'(sticky_flags), 64'(exp_sticky));
    chk("rand_err", 64'(err_mismatch), 64'd0);

`ifdef ALU_ISSUER_CHECK_EN
    // Corrupt one ALU result at capture; the sticky error must survive clear.
    inj = 64'd1;
    single_op(64'd1, 64'd2, 2'b00);
    inj = 64'd0;
    @(negedge clk);
    chk("err_set", 64'(err_mismatch), 64'd1);
    @(posedge clk); #1;
    clear = 1'b1;
    exp_cnt    = 0;
    exp_sticky = 4'd0;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("err_after_clear", 64'(err_mismatch), 64'd1);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("err_after_rst", 64'(err_mismatch), 64'd0);
    @(posedge clk); #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
